// File: rtl/seg7_display_scan.sv
// seg7_display_scan
// Board-level display stage. It shows one of five 32-bit CPU values in hex on an
// 8-digit multiplexed 7-segment display, and a debounced pushbutton steps through
// the sources. All outputs are registered and blank until the first scan tick
// after reset.
module seg7_display_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_sel,
  input  logic [31:0] leddata,
  input  logic [31:0] count_cycle,
  input  logic [31:0] count_branch,
  input  logic [31:0] count_jmp,
  input  logic [31:0] mem_probe,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  src_sel
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic              tick;
  logic [2:0]        digit;
  logic [2:0]        digit_next;
  logic [31:0]       shadow;
  logic [31:0]       shadow_next;
  logic [31:0]       src_word;
  logic              frame_start;
  logic              lit;
  logic              lit_next;
  logic [3:0]        nibble;

  logic              sync1;
  logic              btn_s;
  logic              stable;
  logic [DB_W-1:0]   db_cnt;
  logic              db_done;
  logic              btn_rise;
  logic [2:0]        src_sel_next;

  // Active-low hex segment patterns {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    logic [6:0] pattern;
    case (val)
      4'h0: pattern = 7'h40;
      4'h1: pattern = 7'h79;
      4'h2: pattern = 7'h24;
      4'h3: pattern = 7'h30;
      4'h4: pattern = 7'h19;
      4'h5: pattern = 7'h12;
      4'h6: pattern = 7'h02;
      4'h7: pattern = 7'h78;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h10;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h03;
      4'hC: pattern = 7'h46;
      4'hD: pattern = 7'h21;
      4'hE: pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  assign tick        = (scan_cnt == SCAN_MAX);
  assign frame_start = tick && (digit == 3'd7);
  assign db_done     = (btn_s != stable) && (db_cnt == DB_MAX);
  assign btn_rise    = db_done && btn_s;

  // Select the current source; out-of-range selects fall back to source 0.
  always_comb begin
    src_word = leddata;
    case (src_sel)
      3'd1:    src_word = count_cycle;
      3'd2:    src_word = count_branch;
      3'd3:    src_word = count_jmp;
      3'd4:    src_word = mem_probe;
      default: src_word = leddata;
    endcase
  end

  // Next digit, snapshot, source index and the nibble that the new digit will show.
  always_comb begin
    digit_next   = tick ? digit + 3'd1 : digit;
    shadow_next  = frame_start ? src_word : shadow;
    lit_next     = lit | tick;
    src_sel_next = src_sel;
    if (btn_rise) begin
      src_sel_next = (src_sel >= 3'd4) ? 3'd0 : src_sel + 3'd1;
    end
    nibble = shadow_next[{digit_next, 2'b00} +: 4];
  end

  // Scan divider, digit pointer and frame snapshot.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      scan_cnt <= '0;
      digit    <= 3'd7;
      shadow   <= '0;
      lit      <= 1'b0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + SCAN_W'(1);
      digit    <= digit_next;
      shadow   <= shadow_next;
      lit      <= lit_next;
    end
  end

  // Button synchronizer, debounce counter and source stepping on each accepted press.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      stable  <= 1'b0;
      db_cnt  <= '0;
      src_sel <= 3'd0;
    end else begin
      sync1   <= btn_sel;
      btn_s   <= sync1;
      src_sel <= src_sel_next;
      if (btn_s == stable) begin
        db_cnt <= '0;
      end else if (db_done) begin
        stable <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Registered display drive; dp tracks the source index every cycle once lit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      if (tick) begin
        an  <= ~(8'b1 << digit_next);
        seg <= hex_to_seg(nibble);
      end
      dp <= lit_next ? (digit_next != src_sel_next) : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_display_scan.sv
// tb_seg7_display_scan
// Scoreboard bench for the display scanner with short scan and debounce periods.
// Expected digit frames are queued when a source value is set up and popped at
// every scan tick.
module tb_seg7_display_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DB_CYCLES = 8;

  logic        clk;
  logic        clr;
  logic        btn_sel;
  logic [31:0] leddata;
  logic [31:0] count_cycle;
  logic [31:0] count_branch;
  logic [31:0] count_jmp;
  logic [31:0] mem_probe;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  src_sel;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tb_cnt;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_display_scan #(.SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk          (clk),
    .clr          (clr),
    .btn_sel      (btn_sel),
    .leddata      (leddata),
    .count_cycle  (count_cycle),
    .count_branch (count_branch),
    .count_jmp    (count_jmp),
    .mem_probe    (mem_probe),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .src_sel      (src_sel)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clocks since the last reset release, used to locate scan ticks.
  always @(posedge clk or negedge clr) begin
    if (!clr) tb_cnt <= 0;
    else      tb_cnt <= tb_cnt + 1;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_frame(input logic [31:0] word, input logic [2:0] sel);
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      e.an  = ~(8'b1 << d);
      e.seg = hex_tab[word[d*4 +: 4]];
      e.dp  = (d != int'(sel));
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_tick();
    do begin
      @(posedge clk);
      #1;
    end while (tb_cnt % SCAN_DIV != 0);
  endtask

  task automatic run_ticks(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      wait_tick();
      check_output("sb_empty", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("an", an, e.an);
        check_output("seg", seg, e.seg);
        check_output("dp", dp, e.dp);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_an"}, an, 8'hFF);
    check_output({tag, "_seg"}, seg, 7'h7F);
    check_output({tag, "_dp"}, dp, 1'b1);
    check_output({tag, "_src"}, src_sel, 3'd0);
  endtask

  task automatic press(input int hold);
    btn_sel = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    btn_sel = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus();
    int d_now;
    // Reset state and first frame of zeros
    clr = 1'b0; btn_sel = 1'b0; leddata = '0;
    count_cycle = 32'h1111_1111; count_branch = 32'h2222_2222;
    count_jmp = 32'h3333_3333; mem_probe = 32'h0000_0005;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    clr = 1'b1;
    expect_frame(32'h0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("pre_tick_an", an, 8'hFF);
    run_ticks(8);

    // Full hex frame, twice
    leddata = 32'h89AB_CDEF;
    expect_frame(32'h89AB_CDEF, 3'd0);
    expect_frame(32'h89AB_CDEF, 3'd0);
    run_ticks(16);

    // Mid-frame change is held off until the next frame
    expect_frame(32'h89AB_CDEF, 3'd0);
    expect_frame(32'h0, 3'd0);
    run_ticks(4);
    leddata = 32'h0;
    run_ticks(12);

    // Glitches shorter than the debounce window are ignored
    for (int g = 0; g < 3; g++) press(3);
    check_output("glitch_src", src_sel, 3'd0);

    // First accepted press: step lands exactly DB_CYCLES+2 clocks after the edge
    btn_sel = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check_output("press_early", src_sel, 3'd0);
    @(posedge clk);
    #1;
    check_output("press_edge", src_sel, 3'd1);
    repeat (10) @(posedge clk);
    #1;
    check_output("press_hold", src_sel, 3'd1);
    btn_sel = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_output("release_no_step", src_sel, 3'd1);

    press(20);
    check_output("press2", src_sel, 3'd2);
    press(20);
    check_output("press3", src_sel, 3'd3);
    press(20);
    check_output("press4", src_sel, 3'd4);

    // Source 4 frame, dp on digit 4 only
    do begin
      @(posedge clk);
      #1;
    end while (tb_cnt % (SCAN_DIV * 8) != 0);
    expect_frame(32'h0000_0005, 3'd4);
    run_ticks(8);

    // Wrap 4 -> 0, dp follows the new index immediately
    btn_sel = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_output("press_wrap", src_sel, 3'd0);
    d_now = ((tb_cnt / SCAN_DIV) + 7) % 8;
    check_output("dp_follow", dp, (d_now != 0));
    btn_sel = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Reset in the middle of a frame (digit 5 on display)
    do begin
      @(posedge clk);
      #1;
    end while ((tb_cnt % SCAN_DIV != 0) || (((tb_cnt / SCAN_DIV) % 8) != 6));
    check_output("pre_reset_an", an, 8'hDF);
    clr = 1'b0;
    #1;
    check_reset_state("midframe_reset");
    leddata = 32'h1234_5678;
    @(negedge clk);
    clr = 1'b1;
    expect_frame(32'h1234_5678, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("post_reset_blank", an, 8'hFF);
    run_ticks(8);
  endtask

  initial begin
    apply_stimulus();
    check_output("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
